// File: rtl/intr_dispatcher_if.sv
// Signal bundle between the interrupt dispatcher and the manager / PC mux / control unit.
// The dispatcher takes the slave side; the core-side logic takes the master side.
interface intr_dispatcher_if #(
    parameter int PC_W = 10
);
    logic [7:0]      pending;
    logic [7:0]      active;
    logic            int_enable;
    logic            instr_boundary;
    logic            reti;
    logic [PC_W-1:0] pc_next;
    logic [7:0]      call_intr;
    logic [7:0]      s_return_intr;
    logic            take_intr;
    logic [PC_W-1:0] vector_pc;
    logic            ret_valid;
    logic [PC_W-1:0] ret_pc;
    logic            stall;
    logic            err;

    modport slave (
        input  pending, active, int_enable, instr_boundary, reti, pc_next,
        output call_intr, s_return_intr, take_intr, vector_pc, ret_valid, ret_pc, stall, err
    );

    modport master (
        output pending, active, int_enable, instr_boundary, reti, pc_next,
        input  call_intr, s_return_intr, take_intr, vector_pc, ret_valid, ret_pc, stall, err
    );
endinterface

// File: rtl/intr_dispatcher.sv
// Interrupt dispatcher: takes the highest-priority eligible request, redirects the PC to its
// vector and keeps return addresses on a small LIFO so handlers can nest.
module intr_dispatcher #(
    parameter int              PC_W     = 10,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] VEC_BASE = 10'h3F0
) (
    input  logic             clk,
    input  logic             reset,
    intr_dispatcher_if.slave bus
);
    localparam int SP_W    = $clog2(DEPTH + 1);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE, CALL, RET, SETTLE} state_t;

    function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    // Returns 8 when no bit is set, so "no active interrupt" never blocks a candidate.
    function automatic logic [3:0] lowest_idx(input logic [7:0] v);
        logic [3:0] idx;
        idx = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    state_t          state_q, state_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            err_q, err_d;
    logic [7:0]      call_intr_q, call_intr_d;
    logic [7:0]      s_return_intr_q, s_return_intr_d;
    logic            take_intr_q, take_intr_d;
    logic [PC_W-1:0] vector_pc_q, vector_pc_d;
    logic            ret_valid_q, ret_valid_d;
    logic [PC_W-1:0] ret_pc_q, ret_pc_d;
    logic            stall_q, stall_d;

    logic [PC_W-1:0] stack_q [ENTRIES];

    logic [7:0]      cand;
    logic [3:0]      best_idx;
    logic [3:0]      act_idx;
    logic            eligible;
    logic [SP_W-1:0] sp_m1;
    logic            push_en;

    always_comb begin
        cand     = bus.pending & ~bus.active;
        best_idx = lowest_idx(cand);
        act_idx  = lowest_idx(bus.active);
        sp_m1    = sp_q - SP_W'(1);
        eligible = (cand != 8'd0) && (best_idx < act_idx) && bus.int_enable &&
                   bus.instr_boundary && (sp_q < SP_W'(DEPTH));
    end

    // Outputs are computed one state ahead so every pulse leaves a flop.
    always_comb begin
        state_d         = state_q;
        sp_d            = sp_q;
        err_d           = err_q;
        call_intr_d     = '0;
        s_return_intr_d = '0;
        take_intr_d     = 1'b0;
        vector_pc_d     = '0;
        ret_valid_d     = 1'b0;
        ret_pc_d        = '0;
        stall_d         = 1'b0;
        push_en         = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.reti) begin
                    if (sp_q != '0) begin
                        state_d         = RET;
                        s_return_intr_d = lowest_onehot(bus.active);
                        ret_valid_d     = 1'b1;
                        ret_pc_d        = stack_q[sp_m1[IDX_W-1:0]];
                        stall_d         = 1'b1;
                        sp_d            = sp_m1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (eligible) begin
                    state_d     = CALL;
                    call_intr_d = lowest_onehot(cand);
                    take_intr_d = 1'b1;
                    vector_pc_d = VEC_BASE + PC_W'(best_idx[2:0]);
                    stall_d     = 1'b1;
                    push_en     = 1'b1;
                    sp_d        = sp_q + SP_W'(1);
                end
            end
            CALL, RET: begin
                state_d = SETTLE;
                stall_d = 1'b1;
            end
            SETTLE: begin
                // One dead cycle lets the manager registers reflect the call/return.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            sp_q            <= '0;
            err_q           <= 1'b0;
            call_intr_q     <= '0;
            s_return_intr_q <= '0;
            take_intr_q     <= 1'b0;
            vector_pc_q     <= '0;
            ret_valid_q     <= 1'b0;
            ret_pc_q        <= '0;
            stall_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            sp_q            <= sp_d;
            err_q           <= err_d;
            call_intr_q     <= call_intr_d;
            s_return_intr_q <= s_return_intr_d;
            take_intr_q     <= take_intr_d;
            vector_pc_q     <= vector_pc_d;
            ret_valid_q     <= ret_valid_d;
            ret_pc_q        <= ret_pc_d;
            stall_q         <= stall_d;
        end
    end

    // Return-address storage is pure data; its contents are meaningless while sp is 0.
    always_ff @(posedge clk) begin
        if (push_en) stack_q[sp_q[IDX_W-1:0]] <= bus.pc_next;
    end

    assign bus.call_intr     = call_intr_q;
    assign bus.s_return_intr = s_return_intr_q;
    assign bus.take_intr     = take_intr_q;
    assign bus.vector_pc     = vector_pc_q;
    assign bus.ret_valid     = ret_valid_q;
    assign bus.ret_pc        = ret_pc_q;
    assign bus.stall         = stall_q;
    assign bus.err           = err_q;
endmodule
